// File: rtl/ga_pkg.sv
// Shared GA coprocessor types: request/response payloads, function codes and the
// scheduler FSM encoding.
package ga_pkg;

    localparam int unsigned GA_SCHED_MAX_REQ = 8;

    typedef enum logic [3:0] {
        GA_FUNCT_ADD = 4'h0,
        GA_FUNCT_SUB = 4'h1,
        GA_FUNCT_MUL = 4'h2,
        GA_FUNCT_GP  = 4'h3
    } ga_funct_e;

    typedef struct packed {
        logic        valid;
        ga_funct_e   funct;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [3:0]  tag;
    } ga_req_t;

    typedef struct packed {
        logic        valid;
        logic        busy;
        logic        error;
        logic [31:0] result;
    } ga_resp_t;

    typedef enum logic [1:0] {
        GA_SCHED_IDLE,
        GA_SCHED_ISSUE,
        GA_SCHED_WAIT,
        GA_SCHED_RESP
    } ga_sched_state_e;

endpackage

// File: rtl/ga_rr_arbiter.sv
// Round-robin arbiter: first valid requester at or above rr_ptr_i, with wrap.
// Purely combinational; returns a one-hot grant, the winner index and an any-valid flag.
module ga_rr_arbiter #(
    parameter int unsigned NumReq = 2,
    parameter int unsigned IdxW   = 1
) (
    input  logic [NumReq-1:0] valid_i,
    input  logic [IdxW-1:0]   rr_ptr_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [IdxW-1:0]   idx_o,
    output logic              any_o
);

    // Scan NumReq positions starting at the pointer; the first hit wins.
    always_comb begin : arb
        int unsigned j;
        logic [IdxW-1:0] k;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        k     = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            j = 32'(rr_ptr_i) + i;
            if (j >= NumReq) begin
                j = j - NumReq;
            end
            k = IdxW'(j);
            if (!any_o && valid_i[k]) begin
                any_o    = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = k;
            end
        end
    end

endmodule

// File: rtl/ga_cop_scheduler.sv
// Shares one ga_coprocessor between NumReq requesters with round-robin arbitration,
// one operation in flight, and the response routed to the granted requester only.
// Optional watchdog: define GA_SCHED_TIMEOUT_EN to turn a stuck WAIT into an error response.
module ga_cop_scheduler
    import ga_pkg::*;
#(
    parameter int unsigned NumReq        = 2,
    parameter int unsigned TimeoutCycles = 64,
    parameter int unsigned CntWidth      = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NumReq-1:0]     req_valid_i,
    output logic [NumReq-1:0]     req_ready_o,
    input  ga_req_t [NumReq-1:0]  req_i,
    output logic [NumReq-1:0]     rsp_valid_o,
    input  logic [NumReq-1:0]     rsp_ready_i,
    output ga_resp_t              rsp_o,
    output ga_req_t               cop_req_o,
    input  ga_resp_t              cop_resp_i,
    output logic                  sched_busy_o,
    output logic                  timeout_o
);

    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

    if (NumReq < 2 || NumReq > GA_SCHED_MAX_REQ) begin : g_bad_num_req
        $error("ga_cop_scheduler: NumReq out of range");
    end
    if ((2 ** CntWidth) <= TimeoutCycles) begin : g_bad_cnt_width
        $error("ga_cop_scheduler: CntWidth too narrow for TimeoutCycles");
    end

    ga_sched_state_e   state_q, state_d;
    logic [IdxW-1:0]   rr_q, rr_d;
    logic [IdxW-1:0]   gnt_q, gnt_d;
    ga_req_t           cop_req_q, cop_req_d;
    ga_resp_t          rsp_q, rsp_d;
    logic              cop_valid_q;
    logic              busy_q;
    logic [NumReq-1:0] rsp_valid_q, rsp_valid_d;

    logic [NumReq-1:0] arb_gnt;
    logic [IdxW-1:0]   arb_idx;
    logic              arb_any;

    ga_rr_arbiter #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_arb (
        .valid_i  (req_valid_i),
        .rr_ptr_i (rr_q),
        .gnt_o    (arb_gnt),
        .idx_o    (arb_idx),
        .any_o    (arb_any)
    );

`ifdef GA_SCHED_TIMEOUT_EN
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                timeout_q, timeout_d;

    // Watchdog counter: cleared while issuing, counts every WAIT cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == GA_SCHED_ISSUE) begin
            cnt_d = '0;
        end else if (state_q == GA_SCHED_WAIT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Watchdog state registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    // Next-state logic, arbitration in IDLE and response capture.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        gnt_d       = gnt_q;
        cop_req_d   = cop_req_q;
        rsp_d       = rsp_q;
        req_ready_o = '0;
`ifdef GA_SCHED_TIMEOUT_EN
        timeout_d   = 1'b0;
`endif
        case (state_q)
            GA_SCHED_IDLE: begin
                if (arb_any && !cop_resp_i.busy) begin
                    req_ready_o = arb_gnt;
                    cop_req_d   = req_i[arb_idx];
                    gnt_d       = arb_idx;
                    rr_d        = (arb_idx == IdxW'(NumReq - 1)) ? '0 : arb_idx + 1'b1;
                    state_d     = GA_SCHED_ISSUE;
                end
            end
            GA_SCHED_ISSUE: state_d = GA_SCHED_WAIT;
            GA_SCHED_WAIT: begin
                // A real response beats a watchdog expiry in the same cycle.
                if (cop_resp_i.valid) begin
                    rsp_d   = cop_resp_i;
                    state_d = GA_SCHED_RESP;
                end
`ifdef GA_SCHED_TIMEOUT_EN
                else if (cnt_q == CntWidth'(TimeoutCycles - 1)) begin
                    rsp_d       = '0;
                    rsp_d.error = 1'b1;
                    timeout_d   = 1'b1;
                    state_d     = GA_SCHED_RESP;
                end
`endif
            end
            GA_SCHED_RESP: begin
                if (rsp_ready_i[gnt_q]) begin
                    state_d = GA_SCHED_IDLE;
                end
            end
            default: state_d = GA_SCHED_IDLE;
        endcase
        rsp_valid_d = (state_d == GA_SCHED_RESP) ? (NumReq'(1) << gnt_d) : '0;
    end

    // State and registered outputs, derived from the next state so they line up with it.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= GA_SCHED_IDLE;
            rr_q        <= '0;
            gnt_q       <= '0;
            cop_req_q   <= '0;
            rsp_q       <= '0;
            cop_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            gnt_q       <= gnt_d;
            cop_req_q   <= cop_req_d;
            rsp_q       <= rsp_d;
            cop_valid_q <= (state_d == GA_SCHED_ISSUE);
            busy_q      <= (state_d != GA_SCHED_IDLE);
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Latched payload with the valid bit owned by the FSM.
    always_comb begin
        cop_req_o       = cop_req_q;
        cop_req_o.valid = cop_valid_q;
    end

    assign rsp_o        = rsp_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign sched_busy_o = busy_q;

endmodule
